fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Consumes the serial pixel stream produced by the sprite serializer: one (x, y, colour) triple per cycle while its write enable is high.
- Filters out-of-screen and transparent pixels.
- Buffers the remaining pixels in a small FIFO, converts (x, y) to a linear framebuffer address, and issues single-pixel writes to the framebuffer memory port under a ready handshake.
- Decouples the serializer's one-pixel-per-cycle burst from framebuffer stalls caused by the VGA read arbiter.

Parameters:
- H_RES, 640, screen width in pixels; valid x is 0..H_RES-1.
- V_RES, 480, screen height in pixels; valid y is 0..V_RES-1.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- SKIP_TRANSPARENT, 1, when 1, pixels with colour 8'd0 are discarded.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- pix_we  in  1  input pixel valid; sampled every rising edge; no back-pressure.
- pix_x  in  10  pixel column.
- pix_y  in  10  pixel row.
- pix_data  in  8  pixel colour.
- fb_ready  in  1  framebuffer accepts the write on this edge when high.
- fb_we  out  1  framebuffer write request.
- fb_addr  out  ADDR_W  linear address, y*H_RES + x.
- fb_data  out  8  colour to write.
- fifo_full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky; a valid pixel was dropped because the FIFO was full.
- clear_overflow  in  1  synchronous clear of overflow.
- idle  out  1  FIFO empty and fb_we low.

Behaviour:
Reset
- reset=0 asynchronously clears FIFO pointers and count.
- Outputs take: fb_we=0, fb_addr=0, fb_data=0, overflow=0, fifo_full=0, idle=1.
- Reset mid-burst discards all buffered and in-flight pixels; no partial write is emitted after release.

Input filter (combinational on sampled inputs)
- A pixel is kept when all of the following hold: pix_we=1, pix_x<H_RES, pix_y<V_RES, and NOT (SKIP_TRANSPARENT=1 and pix_data=0).
- Any pixel failing the filter is silently discarded. It does not set overflow.

Address
- Computed before the FIFO write: addr = pix_y*H_RES + pix_x, ADDR_W bits, no truncation for in-range pixels.
- For H_RES=640, implemented as (y<<9)+(y<<7)+x; no multiplier required.
- FIFO entry = {addr, data}.

FIFO
- Push when the pixel is kept AND (count<DEPTH OR pop occurs on the same edge).
- Kept pixel with count=DEPTH and no pop: dropped, overflow<=1.
- overflow cleared by clear_overflow=1. If a drop and clear_overflow coincide, the set wins.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. fifo_full is registered from count.

Output stage (one register: fb_we / fb_addr / fb_data)
- Output-register states:
  - EMPTY (fb_we=0).
  - PENDING (fb_we=1).
- Pop occurs when the FIFO is non-empty AND (EMPTY OR (PENDING AND fb_ready=1)).
  - On pop: the register loads the FIFO head and stays in or enters PENDING.
- PENDING with fb_ready=1 and FIFO empty: go to EMPTY, fb_we<=0.
- PENDING with fb_ready=0: fb_we, fb_addr and fb_data stay stable (held until accepted).
- fb_ready is ignored while fb_we=0.

Timing
- Latency: pixel sampled at edge E0; fb_we=1 with its address from edge E1; write accepted at edge E2 if fb_ready=1.
- Throughput: one write per cycle while fb_ready=1.
- Order: output pixel order equals input order of kept pixels.

Test Plan:
1. Single pixel x=3, y=2, data=8'h1C, fb_ready=1 -> fb_we high for exactly one cycle, starting one cycle after input; fb_addr=1283, fb_data=8'h1C; idle returns to 1.
2. 256-pixel burst, checkerboard colours 8'h00/8'hE0, base (100,50), fb_ready=1 -> exactly 128 writes, only colour 8'hE0, addresses ascending; transparent pixels absent; no overflow.
3. Out-of-range pixels (x=640,y=0), (x=5,y=480), (x=1023,y=1023) -> no write, no FIFO push, overflow stays 0.
4. fb_ready=0, then 20 consecutive opaque pixels -> first 17 retained (16 in FIFO + 1 in output register); fifo_full=1; overflow=1. Then fb_ready=1 -> exactly 17 writes in order; clear_overflow pulse -> overflow=0.
5. FIFO full with fb_ready=1 and a continuous input stream -> simultaneous push/pop each cycle; no drops; overflow stays 0.
6. Assert reset mid-burst with 8 entries pending and fb_we=1 -> outputs zero immediately (asynchronous); after release, no stale writes; idle=1.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Pixel-stream to framebuffer writer: filters off-screen/transparent pixels,
// buffers {address, colour} in a FIFO and drains it through a single output register.
module fb_pixel_writer #(
    parameter int H_RES            = 640,
    parameter int V_RES            = 480,
    parameter int ADDR_W           = 19,
    parameter int DEPTH            = 16,
    parameter int SKIP_TRANSPARENT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pix_we_i,
    input  logic [9:0]        pix_x_i,
    input  logic [9:0]        pix_y_i,
    input  logic [7:0]        pix_data_i,
    input  logic              fb_ready_i,
    input  logic              clear_overflow_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [7:0]        fb_data_o,
    output logic              fifo_full_o,
    output logic              overflow_o,
    output logic              idle_o,
    output logic              dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int E_W   = ADDR_W + 8;
    localparam logic [10:0]      H_LIM    = 11'(H_RES);
    localparam logic [10:0]      V_LIM    = 11'(V_RES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } out_state_e;

    // Input filter and address generation
    logic              transparent;
    logic              keep;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] pix_addr;

    assign transparent = (SKIP_TRANSPARENT != 0) && (pix_data_i == 8'd0);
    assign keep        = pix_we_i && ({1'b0, pix_x_i} < H_LIM) &&
                         ({1'b0, pix_y_i} < V_LIM) && !transparent;
    assign x_ext       = {{(ADDR_W-10){1'b0}}, pix_x_i};
    assign y_ext       = {{(ADDR_W-10){1'b0}}, pix_y_i};

    generate
        if (H_RES == 640) begin : g_shift_addr
            // 640 = 512 + 128, so two shifted adds replace the multiplier.
            assign pix_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_mul_addr
            assign pix_addr = y_ext * ADDR_W'(H_RES) + x_ext;
        end
    endgenerate

    // FIFO storage and control
    logic [E_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_full_q;
    logic              overflow_q, overflow_d;
    logic [E_W-1:0]    head;
    logic              push;
    logic              pop;
    logic              drop;

    // Output register FSM
    out_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    assign head = mem_q[rd_ptr_q];
    assign pop  = (count_q != '0) && ((state_q == ST_EMPTY) || fb_ready_i);
    assign push = keep && ((count_q != CNT_FULL) || pop);
    assign drop = keep && !push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)                  overflow_d = 1'b1;
        else if (clear_overflow_i) overflow_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            state_d = ST_PENDING;
            addr_d  = head[E_W-1:8];
            data_d  = head[7:0];
        end else if ((state_q == ST_PENDING) && fb_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {pix_addr, pix_data_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= ST_EMPTY;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fifo_full_q <= (count_d == CNT_FULL);
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign fb_we_o     = (state_q == ST_PENDING);
    assign fb_addr_o   = addr_q;
    assign fb_data_o   = data_q;
    assign fifo_full_o = fifo_full_q;
    assign overflow_o  = overflow_q;
    assign idle_o      = (count_q == '0) && (state_q == ST_EMPTY);
    assign dbg_state_o = (state_q == ST_PENDING);

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: directed pixel vectors, expected writes queued at
// issue time and compared by a monitor when the framebuffer accepts a write.
module tb_fb_pixel_writer;

    localparam int ADDR_W = 19;
    localparam int W      = ADDR_W + 8;

    logic              clk;
    logic              rst_n;
    logic              pix_we;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [7:0]        pix_data;
    logic              fb_ready;
    logic              clear_overflow;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              fifo_full;
    logic              overflow;
    logic              idle;
    logic              dbg_state;

    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int writes       = 0;

    fb_pixel_writer #(
        .H_RES(640), .V_RES(480), .ADDR_W(ADDR_W), .DEPTH(16), .SKIP_TRANSPARENT(1)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .pix_we_i(pix_we),
        .pix_x_i(pix_x),
        .pix_y_i(pix_y),
        .pix_data_i(pix_data),
        .fb_ready_i(fb_ready),
        .clear_overflow_i(clear_overflow),
        .fb_we_o(fb_we),
        .fb_addr_o(fb_addr),
        .fb_data_o(fb_data),
        .fifo_full_o(fifo_full),
        .overflow_o(overflow),
        .idle_o(idle),
        .dbg_state_o(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] lin_addr(input int x, input int y);
        int a;
        a = y * 640 + x;
        return a[ADDR_W-1:0];
    endfunction

    // Driver: inputs change 2 time units after a rising edge.
    task automatic drive_pixel(input int x, input int y, input logic [7:0] d, input bit exp_keep);
        pix_we   = 1'b1;
        pix_x    = x[9:0];
        pix_y    = y[9:0];
        pix_data = d;
        if (exp_keep) exp_q.push_back({lin_addr(x, y), d});
        @(posedge clk);
        #2;
        pix_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(idle && exp_q.size() == 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, idle && (exp_q.size() == 0)}, 32'd1);
        @(posedge clk);
        #2;
    endtask

    // Monitor: a write is accepted at the next rising edge when fb_we && fb_ready.
    always @(negedge clk) begin
        if (rst_n && fb_we && fb_ready) begin
            writes++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", fb_addr, fb_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                tests_run++;
                if ({fb_addr, fb_data} !== e) begin
                    tests_failed++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             fb_addr, fb_data, e[W-1:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int w0;
        rst_n = 1'b0; pix_we = 1'b0; pix_x = '0; pix_y = '0; pix_data = '0;
        fb_ready = 1'b1; clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("rst_fb_we", {31'd0, fb_we}, 32'd0);
        check("rst_fb_addr", {13'd0, fb_addr}, 32'd0);
        check("rst_fb_data", {24'd0, fb_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);

        // 1: single pixel latency and address
        drive_pixel(3, 2, 8'h1C, 1'b1);
        check("t1_we_e0", {31'd0, fb_we}, 32'd0);
        @(posedge clk); #2;
        check("t1_we_e1", {31'd0, fb_we}, 32'd1);
        check("t1_addr", {13'd0, fb_addr}, 32'd1283);
        check("t1_data", {24'd0, fb_data}, 32'h1C);
        @(posedge clk); #2;
        check("t1_we_e2", {31'd0, fb_we}, 32'd0);
        check("t1_idle", {31'd0, idle}, 32'd1);

        // 2: 16x16 checkerboard burst, transparent squares vanish
        w0 = writes;
        for (int i = 0; i < 256; i++) begin
            int c, r;
            c = i % 16;
            r = i / 16;
            if (((c + r) % 2) == 1) drive_pixel(100 + c, 50 + r, 8'hE0, 1'b1);
            else                    drive_pixel(100 + c, 50 + r, 8'h00, 1'b0);
        end
        wait_idle("t2_drain");
        check("t2_writes", writes - w0, 32'd128);
        check("t2_overflow", {31'd0, overflow}, 32'd0);

        // 3: off-screen pixels never enter the FIFO
        w0 = writes;
        drive_pixel(640, 0, 8'h55, 1'b0);
        check("t3_idle_a", {31'd0, idle}, 32'd1);
        drive_pixel(5, 480, 8'h55, 1'b0);
        check("t3_idle_b", {31'd0, idle}, 32'd1);
        drive_pixel(1023, 1023, 8'h55, 1'b0);
        check("t3_idle_c", {31'd0, idle}, 32'd1);
        repeat (4) @(posedge clk);
        #2;
        check("t3_writes", writes - w0, 32'd0);
        check("t3_overflow", {31'd0, overflow}, 32'd0);

        // 4: stalled framebuffer, 17 retained and 3 dropped
        fb_ready = 1'b0;
        w0 = writes;
        for (int i = 0; i < 20; i++) drive_pixel(i, 10, 8'(i + 1), i < 17);
        check("t4_fifo_full", {31'd0, fifo_full}, 32'd1);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        check("t4_hold_we", {31'd0, fb_we}, 32'd1);
        check("t4_hold_addr", {13'd0, fb_addr}, 32'd6400);
        check("t4_hold_data", {24'd0, fb_data}, 32'h01);
        fb_ready = 1'b1;
        wait_idle("t4_drain");
        check("t4_writes", writes - w0, 32'd17);
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);
        clear_overflow = 1'b1;
        @(posedge clk); #2;
        clear_overflow = 1'b0;
        check("t4_overflow_clr", {31'd0, overflow}, 32'd0);

        // 5: full FIFO streaming with simultaneous push/pop
        fb_ready = 1'b0;
        w0 = writes;
        for (int i = 0; i < 17; i++) drive_pixel(200 + i, 300, 8'h80 + 8'(i), 1'b1);
        check("t5_full_pre", {31'd0, fifo_full}, 32'd1);
        check("t5_ovf_pre", {31'd0, overflow}, 32'd0);
        fb_ready = 1'b1;
        for (int i = 0; i < 30; i++) drive_pixel(400 + i, 400, 8'h20 + 8'(i), 1'b1);
        check("t5_full_stream", {31'd0, fifo_full}, 32'd1);
        wait_idle("t5_drain");
        check("t5_writes", writes - w0, 32'd47);
        check("t5_overflow", {31'd0, overflow}, 32'd0);

        // 6: asynchronous reset with eight entries queued and a write pending
        fb_ready = 1'b0;
        w0 = writes;
        for (int i = 0; i < 9; i++) drive_pixel(50 + i, 60, 8'h33, 1'b1);
        check("t6_we_pre", {31'd0, fb_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_rst_we", {31'd0, fb_we}, 32'd0);
        check("t6_rst_addr", {13'd0, fb_addr}, 32'd0);
        check("t6_rst_data", {24'd0, fb_data}, 32'd0);
        check("t6_rst_idle", {31'd0, idle}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        fb_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("t6_writes", writes - w0, 32'd0);
        check("t6_idle", {31'd0, idle}, 32'd1);
        check("t6_fifo_full", {31'd0, fifo_full}, 32'd0);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
